// File: rtl/eu_pipe.sv
// rtl/eu_pipe.sv - execution unit with two-cycle load, iterative multiply and writeback forwarding
module eu_pipe #(
    parameter int DATA_W    = 8,
    parameter int REG_ADR_W = 3,
    parameter int MEM_ADR_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic [3:0]           opcode,
    input  logic [REG_ADR_W-1:0] op_a_adr,
    input  logic [REG_ADR_W-1:0] op_b_adr,
    input  logic [REG_ADR_W-1:0] dest_reg,
    output logic [REG_ADR_W-1:0] op_a_send_adr,
    output logic [REG_ADR_W-1:0] op_b_send_adr,
    input  logic [DATA_W-1:0]    operand_a,
    input  logic [DATA_W-1:0]    operand_b,
    output logic [MEM_ADR_W-1:0] dm_addr,
    output logic [DATA_W-1:0]    dm_wdata,
    output logic                 dm_we,
    output logic                 dm_re,
    input  logic [DATA_W-1:0]    dm_rdata,
    output logic                 wb_valid,
    output logic [REG_ADR_W-1:0] wb_reg,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 flag_z,
    output logic                 flag_c,
    output logic                 flag_n,
    output logic                 flag_v,
    output logic                 illegal_op
);

    localparam int SH_W  = $clog2(DATA_W);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_OR    = 4'b0110;
    localparam logic [3:0] OP_XOR   = 4'b0111;
    localparam logic [3:0] OP_SHL   = 4'b1000;
    localparam logic [3:0] OP_SHR   = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_CMP   = 4'b1011;

    typedef enum logic [1:0] {Idle, LoadWait, MulBusy, MulWb} stateT;

    stateT                 state;
    stateT                 stateNext;
    logic                  accept;
    logic                  loadWb;
    logic [DATA_W-1:0]     wbDataQ;
    logic [DATA_W-1:0]     srcA;
    logic [DATA_W-1:0]     srcB;
    logic [MEM_ADR_W-1:0]  memAddr;
    logic [SH_W-1:0]       shAmt;
    logic [DATA_W:0]       addWide;
    logic [DATA_W:0]       subWide;
    logic [DATA_W:0]       shlWide;
    logic [DATA_W:0]       shrWide;
    logic [DATA_W-1:0]     aluRes;
    logic                  aluC;
    logic                  aluV;
    logic                  aluWb;
    logic                  aluFlg;
    logic [2*DATA_W-1:0]   mulAcc;
    logic [2*DATA_W-1:0]   mulCand;
    logic [2*DATA_W-1:0]   mulSum;
    logic [DATA_W-1:0]     mulPlier;
    logic [CNT_W-1:0]      mulCnt;
    logic                  mulLast;

    assign op_a_send_adr = op_a_adr;
    assign op_b_send_adr = op_b_adr;

    // Load data is passed straight through in its writeback cycle, then held.
    assign wb_data = loadWb ? dm_rdata : wbDataQ;

    assign accept = issue_valid && (state == Idle);
    assign srcA   = (wb_valid && (wb_reg == op_a_adr)) ? wb_data : operand_a;
    assign srcB   = (wb_valid && (wb_reg == op_b_adr)) ? wb_data : operand_b;

    assign memAddr = MEM_ADR_W'(srcA);
    assign shAmt   = srcB[SH_W-1:0];
    assign addWide = {1'b0, srcA} + {1'b0, srcB};
    assign subWide = {1'b0, srcA} - {1'b0, srcB};
    // Extra bit on the shifted-out side catches the last bit lost (0 when shAmt is 0).
    assign shlWide = {1'b0, srcA} << shAmt;
    assign shrWide = {srcA, 1'b0} >> shAmt;

    assign mulSum  = mulAcc + (mulPlier[0] ? mulCand : '0);
    assign mulLast = (mulCnt == CNT_W'(DATA_W - 1));

    // Single-cycle ALU result, carry/overflow and writeback/flag enables.
    always_comb begin
        aluRes = '0;
        aluC   = 1'b0;
        aluV   = 1'b0;
        aluWb  = 1'b0;
        aluFlg = 1'b0;
        case (opcode)
            OP_ADD: begin
                aluRes = addWide[DATA_W-1:0];
                aluC   = addWide[DATA_W];
                aluV   = (srcA[MSB] == srcB[MSB]) && (aluRes[MSB] != srcA[MSB]);
                aluWb  = 1'b1;
                aluFlg = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                aluRes = subWide[DATA_W-1:0];
                aluC   = subWide[DATA_W];
                aluV   = (srcA[MSB] != srcB[MSB]) && (aluRes[MSB] != srcA[MSB]);
                aluWb  = (opcode == OP_SUB);
                aluFlg = 1'b1;
            end
            OP_AND: begin
                aluRes = srcA & srcB;
                aluWb  = 1'b1;
                aluFlg = 1'b1;
            end
            OP_OR: begin
                aluRes = srcA | srcB;
                aluWb  = 1'b1;
                aluFlg = 1'b1;
            end
            OP_XOR: begin
                aluRes = srcA ^ srcB;
                aluWb  = 1'b1;
                aluFlg = 1'b1;
            end
            OP_SHL: begin
                aluRes = shlWide[DATA_W-1:0];
                aluC   = shlWide[DATA_W];
                aluWb  = 1'b1;
                aluFlg = 1'b1;
            end
            OP_SHR: begin
                aluRes = shrWide[DATA_W:1];
                aluC   = shrWide[0];
                aluWb  = 1'b1;
                aluFlg = 1'b1;
            end
            default: ;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= Idle;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and issue handshake: only loads and multiplies stall the issuer.
    always_comb begin
        stateNext   = state;
        issue_ready = 1'b0;
        case (state)
            Idle: begin
                issue_ready = 1'b1;
                if (accept && (opcode == OP_LOAD)) begin
                    stateNext = LoadWait;
                end else if (accept && (opcode == OP_MUL)) begin
                    stateNext = MulBusy;
                end
            end
            LoadWait: stateNext = Idle;
            MulBusy:  if (mulLast) stateNext = MulWb;
            MulWb:    stateNext = Idle;
            default:  stateNext = Idle;
        endcase
    end

    // Datapath: strobes, writeback, flags and the shift-add multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dm_addr    <= '0;
            dm_wdata   <= '0;
            dm_we      <= 1'b0;
            dm_re      <= 1'b0;
            wb_valid   <= 1'b0;
            wb_reg     <= '0;
            wbDataQ    <= '0;
            loadWb     <= 1'b0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            flag_n     <= 1'b0;
            flag_v     <= 1'b0;
            illegal_op <= 1'b0;
            mulAcc     <= '0;
            mulCand    <= '0;
            mulPlier   <= '0;
            mulCnt     <= '0;
        end else begin
            dm_we      <= 1'b0;
            dm_re      <= 1'b0;
            wb_valid   <= 1'b0;
            loadWb     <= 1'b0;
            illegal_op <= 1'b0;
            if (loadWb) begin
                wbDataQ <= dm_rdata;
            end
            case (state)
                Idle: begin
                    if (accept) begin
                        if (opcode[3:2] == 2'b11) begin
                            illegal_op <= 1'b1;
                        end
                        case (opcode)
                            OP_LOAD: begin
                                dm_re   <= 1'b1;
                                dm_addr <= memAddr;
                                wb_reg  <= dest_reg;
                            end
                            OP_STORE: begin
                                dm_we    <= 1'b1;
                                dm_addr  <= memAddr;
                                dm_wdata <= srcB;
                            end
                            OP_MUL: begin
                                // Bit 0 of the multiplier is consumed at accept.
                                mulAcc   <= srcB[0] ? {{DATA_W{1'b0}}, srcA} : '0;
                                mulCand  <= {{(DATA_W-1){1'b0}}, srcA, 1'b0};
                                mulPlier <= srcB >> 1;
                                mulCnt   <= CNT_W'(1);
                                wb_reg   <= dest_reg;
                            end
                            default: begin
                                if (aluWb) begin
                                    wb_valid <= 1'b1;
                                    wb_reg   <= dest_reg;
                                    wbDataQ  <= aluRes;
                                end
                                if (aluFlg) begin
                                    flag_z <= (aluRes == '0);
                                    flag_n <= aluRes[MSB];
                                    flag_c <= aluC;
                                    flag_v <= aluV;
                                end
                            end
                        endcase
                    end
                end
                LoadWait: begin
                    wb_valid <= 1'b1;
                    loadWb   <= 1'b1;
                end
                MulBusy: begin
                    if (mulLast) begin
                        wb_valid <= 1'b1;
                        wbDataQ  <= mulSum[DATA_W-1:0];
                        flag_z   <= (mulSum[DATA_W-1:0] == '0);
                        flag_n   <= mulSum[MSB];
                        flag_c   <= |mulSum[2*DATA_W-1:DATA_W];
                        flag_v   <= |mulSum[2*DATA_W-1:DATA_W];
                    end else begin
                        mulAcc   <= mulSum;
                        mulCand  <= mulCand << 1;
                        mulPlier <= mulPlier >> 1;
                        mulCnt   <= mulCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eu_pipe.sv
// tb/tb_eu_pipe.sv - directed and random checks of eu_pipe against an architectural model
module tb_eu_pipe;

    localparam int W  = 8;
    localparam int RW = 3;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          issueValid;
    logic          issueReady;
    logic [3:0]    opcode;
    logic [RW-1:0] opAAdr, opBAdr, destReg, opASendAdr, opBSendAdr;
    logic [W-1:0]  operandA, operandB;
    logic [MW-1:0] dmAddr;
    logic [W-1:0]  dmWdata, dmRdata;
    logic          dmWe, dmRe;
    logic          wbValid;
    logic [RW-1:0] wbReg;
    logic [W-1:0]  wbData;
    logic          flagZ, flagC, flagN, flagV, illegalOp;
    logic [3:0]    flags;

    logic [W-1:0]  rf [8];
    logic [W-1:0]  mem [256];
    logic          rfPreWe, memPreWe;
    logic [2:0]    rfPreAdr;
    logic [7:0]    rfPreData, memPreAdr, memPreData;

    int            mrf [8];
    int            mmem [256];
    logic [3:0]    mflags;
    int            testCount = 0;
    int            failCount = 0;

    always #5 clk = ~clk;

    eu_pipe #(.DATA_W(W), .REG_ADR_W(RW), .MEM_ADR_W(MW)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issueValid), .issue_ready(issueReady), .opcode(opcode),
        .op_a_adr(opAAdr), .op_b_adr(opBAdr), .dest_reg(destReg),
        .op_a_send_adr(opASendAdr), .op_b_send_adr(opBSendAdr),
        .operand_a(operandA), .operand_b(operandB),
        .dm_addr(dmAddr), .dm_wdata(dmWdata), .dm_we(dmWe), .dm_re(dmRe), .dm_rdata(dmRdata),
        .wb_valid(wbValid), .wb_reg(wbReg), .wb_data(wbData),
        .flag_z(flagZ), .flag_c(flagC), .flag_n(flagN), .flag_v(flagV),
        .illegal_op(illegalOp)
    );

    assign flags    = {flagZ, flagC, flagN, flagV};
    assign operandA = rf[opASendAdr];
    assign operandB = rf[opBSendAdr];

    always @(posedge clk) begin
        if (wbValid) rf[wbReg] <= wbData;
        if (rfPreWe) rf[rfPreAdr] <= rfPreData;
    end

    always @(posedge clk) begin
        if (memPreWe) mem[memPreAdr] <= memPreData;
        if (dmWe) mem[dmAddr] <= dmWdata;
        if (dmRe) dmRdata <= mem[dmAddr];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Architectural result of one instruction; flags packed as {Z,C,N,V}.
    function automatic void refOp(input int op, input int a, input int b,
                                  output int res, output bit wb, output bit fl,
                                  output logic [3:0] f);
        int sa, sb, sr, sh, full;
        bit c, v;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sh = b % W;
        res = 0; wb = 0; fl = 0; c = 0; v = 0;
        case (op)
            1: begin
                full = a + b; res = full % 256; c = (full > 255);
                sr = sa + sb; v = (sr > 127) || (sr < -128); wb = 1; fl = 1;
            end
            2, 11: begin
                res = (a - b + 256) % 256; c = (a < b);
                sr = sa - sb; v = (sr > 127) || (sr < -128); wb = (op == 2); fl = 1;
            end
            3: begin res = a & b; wb = 1; fl = 1; end
            6: begin res = a | b; wb = 1; fl = 1; end
            7: begin res = a ^ b; wb = 1; fl = 1; end
            8: begin
                res = (a << sh) % 256; c = (sh == 0) ? 0 : ((a >> (W - sh)) & 1);
                wb = 1; fl = 1;
            end
            9: begin
                res = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1);
                wb = 1; fl = 1;
            end
            10: begin
                full = a * b; res = full % 256; c = (full > 255); v = c; wb = 1; fl = 1;
            end
            default: ;
        endcase
        f = {(res == 0), c, (res >= 128), v};
    endfunction

    task automatic setReg(input int r, input int v);
        @(negedge clk);
        rfPreWe = 1'b1; rfPreAdr = 3'(r); rfPreData = 8'(v);
        @(negedge clk);
        rfPreWe = 1'b0;
        mrf[r] = v;
    endtask

    task automatic setMem(input int adr, input int v);
        @(negedge clk);
        memPreWe = 1'b1; memPreAdr = 8'(adr); memPreData = 8'(v);
        @(negedge clk);
        memPreWe = 1'b0;
        mmem[adr] = v;
    endtask

    // Presents one instruction and returns #1 after the accepting edge (cycle T+1).
    task automatic issueOp(input int op, input int ra, input int rb, input int rd);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (issueReady !== 1'b1 && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        check("issue_ready_wait", issueReady, 1);
        issueValid = 1'b1; opcode = 4'(op);
        opAAdr = 3'(ra); opBAdr = 3'(rb); destReg = 3'(rd);
        @(posedge clk);
        #1;
        issueValid = 1'b0;
    endtask

    task automatic runOp(input int op, input int ra, input int rb, input int rd);
        int a, b, res;
        bit wb, fl;
        logic [3:0] f, oldFlags;
        a = mrf[ra]; b = mrf[rb];
        refOp(op, a, b, res, wb, fl, f);
        oldFlags = mflags;
        issueOp(op, ra, rb, rd);
        check("illegal_op", illegalOp, op >= 12);
        if (op == 4) begin
            check("load_re", dmRe, 1);
            check("load_addr", dmAddr, a);
            check("load_ready_low", issueReady, 0);
            check("load_wb_early", wbValid, 0);
            @(posedge clk); #1;
            check("load_wb_valid", wbValid, 1);
            check("load_wb_reg", wbReg, rd);
            check("load_wb_data", wbData, mmem[a]);
            check("load_ready_back", issueReady, 1);
            check("load_flags", flags, oldFlags);
            mrf[rd] = mmem[a];
        end else if (op == 5) begin
            check("store_we", dmWe, 1);
            check("store_addr", dmAddr, a);
            check("store_wdata", dmWdata, b);
            check("store_no_wb", wbValid, 0);
            check("store_flags", flags, oldFlags);
            mmem[a] = b;
        end else if (op == 10) begin
            for (int k = 1; k < W; k++) begin
                check("mul_ready_low", issueReady, 0);
                check("mul_wb_early", wbValid, 0);
                @(posedge clk); #1;
            end
            check("mul_wb_valid", wbValid, 1);
            check("mul_wb_reg", wbReg, rd);
            check("mul_wb_data", wbData, res);
            check("mul_flags", flags, f);
            mrf[rd] = res;
            mflags = f;
        end else begin
            check("alu_dm_strobes", {dmWe, dmRe}, 0);
            check("alu_wb_valid", wbValid, wb);
            if (wb) begin
                check("alu_wb_reg", wbReg, rd);
                check("alu_wb_data", wbData, res);
                mrf[rd] = res;
            end
            if (fl) mflags = f;
            check("alu_flags", flags, mflags);
        end
    endtask

    initial begin
        reset = 1'b1; issueValid = 1'b0; opcode = '0;
        opAAdr = 3'd5; opBAdr = 3'd6; destReg = '0;
        rfPreWe = 1'b0; memPreWe = 1'b0; rfPreAdr = '0; rfPreData = '0;
        memPreAdr = '0; memPreData = '0;
        mflags = 4'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", issueReady, 1);
        check("rst_wb_valid", wbValid, 0);
        check("rst_wb_data", wbData, 0);
        check("rst_flags", flags, 0);
        check("rst_dm", {dmWe, dmRe, dmAddr, dmWdata}, 0);
        check("rst_illegal", illegalOp, 0);
        check("rst_send_adr", {opASendAdr, opBSendAdr}, {3'd5, 3'd6});
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            memPreWe = 1'b1; memPreAdr = 8'(i); memPreData = 8'($urandom_range(0, 255));
            mmem[i] = int'(memPreData);
        end
        @(negedge clk);
        memPreWe = 1'b0;
        for (int r = 0; r < 8; r++) setReg(r, $urandom_range(0, 255));

        // Basic add, load, store
        setReg(4, 8'h01); setReg(5, 8'h02);
        runOp(1, 4, 5, 2);
        setMem(8'h10, 8'hAB); setReg(1, 8'h10);
        runOp(4, 1, 0, 6);
        setReg(1, 8'h20); setReg(2, 8'h5A);
        runOp(5, 1, 2, 0);

        // Wraparound, borrow/overflow, compare-only
        setReg(4, 8'hFF); setReg(5, 8'h01);
        runOp(1, 4, 5, 6);
        setReg(4, 8'h80);
        runOp(2, 4, 5, 6);
        setReg(4, 8'h05); setReg(5, 8'h05);
        runOp(11, 4, 5, 6);

        // Shift edge amounts
        setReg(4, 8'h81); setReg(5, 8'h00);
        runOp(8, 4, 5, 6);
        setReg(5, 8'h07);
        runOp(8, 4, 5, 6);
        runOp(9, 4, 5, 6);

        // Multiply, then multiply aborted by reset
        setReg(2, 8'h10); setReg(3, 8'h11);
        runOp(10, 2, 3, 4);
        issueOp(10, 2, 3, 5);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #2;
        check("abort_ready", issueReady, 1);
        @(negedge clk);
        reset = 1'b0;
        mflags = 4'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("abort_no_wb", wbValid, 0);
            check("abort_no_dm", {dmWe, dmRe}, 0);
        end
        check("abort_flags", flags, 0);

        // Back-to-back forwarding and illegal opcode
        setReg(6, 8'h01); setReg(1, 8'h00);
        runOp(1, 6, 6, 1);
        runOp(1, 1, 1, 3);
        runOp(14, 3, 3, 7);
        runOp(0, 3, 3, 7);

        // Load followed immediately by a consumer of the loaded value
        setReg(1, 8'h10);
        runOp(4, 1, 0, 2);
        runOp(7, 2, 2, 5);

        for (int i = 0; i < 200; i++) begin
            if (i % 25 == 0) setReg($urandom_range(0, 7), $urandom_range(0, 255));
            runOp($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
